vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter c_TOTAL_COLS, default 800: pixels per line, including blanking.
REQ-002 Parameter c_TOTAL_ROWS, default 525: lines per frame, including blanking.
REQ-003 Parameter c_ACTIVE_COLS, default 640: visible pixels per line.
REQ-004 Parameter c_ACTIVE_ROWS, default 480: visible lines per frame.
REQ-005 Horizontal porch and sync parameters, defaults: c_H_FRONT_PORCH 16, c_H_SYNC_WIDTH 96, c_H_BACK_PORCH 48.
REQ-006 Vertical porch and sync parameters, defaults: c_V_FRONT_PORCH 10, c_V_SYNC_WIDTH 2, c_V_BACK_PORCH 33.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset: i_Clk input 1, pixel clock; i_Rst input 1, reset.
REQ-008 o_HSync output 1: horizontal sync, active low.
REQ-009 o_VSync output 1: vertical sync, active low.
REQ-010 o_Col_Count output 10: current column; o_Row_Count output 10: current row.
REQ-011 o_Active output 1: high when the pixel is inside the visible area.
REQ-012 o_Frame_Start output 1: single-cycle pulse at pixel (0,0).
REQ-013 o_Frame_Count output 8: frame counter.
REQ-014 o_Red_Video, o_Grn_Video, o_Blu_Video outputs 4 each: test-pattern colour.

Function
REQ-015 Internal column counter SHALL count 0..c_TOTAL_COLS-1 and wrap to 0.
REQ-016 Internal row counter SHALL advance only on column wrap, count 0..c_TOTAL_ROWS-1 and wrap to 0.
REQ-017 All outputs SHALL be registered decodes of the internal counters, so every output is mutually aligned and lags the internal counters by exactly one cycle.
REQ-018 o_Active=1 iff col<c_ACTIVE_COLS and row<c_ACTIVE_ROWS.
REQ-019 o_HSync=0 iff col is in [ACTIVE+H_FRONT, ACTIVE+H_FRONT+H_SYNC-1]; with defaults, 656..751.
REQ-020 o_VSync=0 iff row is in [ACTIVE+V_FRONT, ACTIVE+V_FRONT+V_SYNC-1]; with defaults, 490..491, on every column of those rows.
REQ-021 o_Frame_Start=1 exactly on the cycle where the outputs show (0,0).
REQ-022 o_Frame_Count SHALL be 0 during the first frame after reset, increment on every later o_Frame_Start, and wrap 255->0.
REQ-023 Each axis SHALL be tracked by a phase FSM with states ACTIVE->FRONT->SYNC->BACK->ACTIVE; each transition occurs on the terminal count of the phase.
REQ-024 Sync and active decodes SHALL come from the FSM state, not from magnitude comparators.
REQ-025 A parameter set whose phases do not sum to c_TOTAL_COLS or c_TOTAL_ROWS SHALL fail elaboration.

Reset
REQ-026 While i_Rst=1, the following SHALL hold: internal counters 0,0; FSMs in ACTIVE; o_HSync=1; o_VSync=1; o_Active=0; o_Frame_Start=0; o_Frame_Count=0; o_Col_Count=0; o_Row_Count=0; colour outputs 0.
REQ-027 On the first clock edge with i_Rst=0, the outputs SHALL show (0,0) with o_Active=1 and o_Frame_Start=1.
REQ-028 Reset asserted mid-frame SHALL take effect on the next edge, with no partial sync pulse extended.

Configuration
REQ-029 Macro VGA_SYNC_GEN_TEST_PATTERN_EN defined: the colour outputs SHALL show 8 vertical bars of c_ACTIVE_COLS/8 pixels each, in the order white, yellow, cyan, green, magenta, red, blue, black.
REQ-030 Each bar channel SHALL be 4'hF or 4'h0, aligned with o_Active, and 0 outside the active area.
REQ-031 Macro undefined: the colour ports SHALL remain and be tied to 4'h0, with no pattern logic synthesised.

Structure
REQ-032 The shared package vga_timing_pkg SHALL hold:
- the phase enum (ACTIVE, FRONT, SYNC, BACK);
- the default 640x480 timing constants;
- the bar colour table.
REQ-033 One sub-module, vga_axis_timer, SHALL be instantiated twice (horizontal and vertical).
REQ-034 vga_axis_timer SHALL contain:
- counter, phase FSM and count-enable input;
- outputs for terminal-count, sync_n and active.
- The horizontal terminal-count drives the vertical enable.

Verification
REQ-035 Release reset -> first cycle shows Col=0, Row=0, Active=1, Frame_Start=1, Frame_Count=0.
REQ-036 Run 800 cycles -> HSync low for exactly 96 consecutive cycles at cols 656..751; Active high for 640 cycles.
REQ-037 Run 2 frames -> Frame_Start period 420000 cycles; VSync low for 1600 cycles at rows 490..491; Frame_Count=1 in frame 2.
REQ-038 Assert reset at row 300, col 700 for 3 cycles -> reset values held, then restart at (0,0) with Frame_Start=1.
REQ-039 With VGA_SYNC_GEN_TEST_PATTERN_EN defined:
- col 85, row 10 -> R=F, G=F, B=0;
- col 600 -> all 0;
- col 640 -> all 0.
REQ-040 Shrink the parameters to 20x10 total (16x6 active) and run 256 frames -> Frame_Count wraps 255->0 and the sync widths match the overridden parameters.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared axis phase enum, default 640x480 timing and colour-bar table
package vga_timing_pkg;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FRONT  = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BACK   = 48;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FRONT  = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 33;
  localparam int unsigned V_TOTAL  = 525;
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one display axis, position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned c_ACTIVE = H_ACTIVE,
  parameter int unsigned c_FRONT  = H_FRONT,
  parameter int unsigned c_SYNC   = H_SYNC,
  parameter int unsigned c_BACK   = H_BACK
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [9:0] cnt_o,
  output logic       tc_o,
  output logic       sync_n_o,
  output logic       active_o
);
  localparam logic [9:0] END_A = 10'(c_ACTIVE - 1);
  localparam logic [9:0] END_F = 10'(c_ACTIVE + c_FRONT - 1);
  localparam logic [9:0] END_S = 10'(c_ACTIVE + c_FRONT + c_SYNC - 1);
  localparam logic [9:0] END_B = 10'(c_ACTIVE + c_FRONT + c_SYNC + c_BACK - 1);
  logic [9:0] cnt_q, cnt_d;
  phase_e     phase_q, phase_d;
  logic       last;
  assign last = cnt_q == END_B;
  always_comb begin
    cnt_d   = en_i ? (last ? 10'd0 : cnt_q + 10'd1) : cnt_q;
    phase_d = !en_i                                  ? phase_q :
              (phase_q == ACTIVE && cnt_q == END_A)  ? FRONT   :
              (phase_q == FRONT  && cnt_q == END_F)  ? SYNC    :
              (phase_q == SYNC   && cnt_q == END_S)  ? BACK    :
              (phase_q == BACK   && last)            ? ACTIVE  : phase_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign cnt_o    = cnt_q;
  assign tc_o     = en_i & last;
  assign sync_n_o = phase_q != SYNC;
  assign active_o = phase_q == ACTIVE;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with registered outputs; VGA_SYNC_GEN_TEST_PATTERN_EN adds colour bars
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned c_TOTAL_COLS    = H_TOTAL,
  parameter int unsigned c_TOTAL_ROWS    = V_TOTAL,
  parameter int unsigned c_ACTIVE_COLS   = H_ACTIVE,
  parameter int unsigned c_ACTIVE_ROWS   = V_ACTIVE,
  parameter int unsigned c_H_FRONT_PORCH = H_FRONT,
  parameter int unsigned c_H_SYNC_WIDTH  = H_SYNC,
  parameter int unsigned c_H_BACK_PORCH  = H_BACK,
  parameter int unsigned c_V_FRONT_PORCH = V_FRONT,
  parameter int unsigned c_V_SYNC_WIDTH  = V_SYNC,
  parameter int unsigned c_V_BACK_PORCH  = V_BACK
)(
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count,
  output logic [3:0] o_Red_Video,
  output logic [3:0] o_Grn_Video,
  output logic [3:0] o_Blu_Video
);
  if (c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC_WIDTH + c_H_BACK_PORCH != c_TOTAL_COLS) begin : g_h_bad
    $error("horizontal phases do not sum to c_TOTAL_COLS");
  end
  if (c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC_WIDTH + c_V_BACK_PORCH != c_TOTAL_ROWS) begin : g_v_bad
    $error("vertical phases do not sum to c_TOTAL_ROWS");
  end
  logic [9:0] col, row, col_q, row_q;
  logic [7:0] fc_q;
  logic       h_tc, v_tc, h_sync_n, v_sync_n, h_act, v_act;
  logic       hs_q, vs_q, act_q, fs_q, wrap_q;
  vga_axis_timer #(
    .c_ACTIVE(c_ACTIVE_COLS), .c_FRONT(c_H_FRONT_PORCH), .c_SYNC(c_H_SYNC_WIDTH), .c_BACK(c_H_BACK_PORCH)
  ) u_h (
    .clk(i_Clk), .rst(i_Rst), .en_i(1'b1), .cnt_o(col), .tc_o(h_tc), .sync_n_o(h_sync_n), .active_o(h_act)
  );
  vga_axis_timer #(
    .c_ACTIVE(c_ACTIVE_ROWS), .c_FRONT(c_V_FRONT_PORCH), .c_SYNC(c_V_SYNC_WIDTH), .c_BACK(c_V_BACK_PORCH)
  ) u_v (
    .clk(i_Clk), .rst(i_Rst), .en_i(h_tc), .cnt_o(row), .tc_o(v_tc), .sync_n_o(v_sync_n), .active_o(v_act)
  );
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      act_q  <= 1'b0;
      fs_q   <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      wrap_q <= 1'b0;
      fc_q   <= '0;
    end else begin
      hs_q   <= h_sync_n;
      vs_q   <= v_sync_n;
      act_q  <= h_act & v_act;
      fs_q   <= col == 10'd0 && row == 10'd0;
      col_q  <= col;
      row_q  <= row;
      wrap_q <= v_tc;
      fc_q   <= fc_q + 8'(wrap_q);
    end
  end
  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_Active      = act_q;
  assign o_Frame_Start = fs_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Frame_Count = fc_q;
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(c_ACTIVE_COLS / 8);
  logic [2:0]  rgb_d;
  logic [11:0] rgb_q;
  assign rgb_d = BAR_RGB[3'(col / BAR_W)];
  always_ff @(posedge i_Clk) begin
    if (i_Rst) rgb_q <= '0;
    else rgb_q <= (h_act & v_act) ? {{4{rgb_d[2]}}, {4{rgb_d[1]}}, {4{rgb_d[0]}}} : 12'h000;
  end
  assign {o_Red_Video, o_Grn_Video, o_Blu_Video} = rgb_q;
`else
  assign o_Red_Video = 4'h0;
  assign o_Grn_Video = 4'h0;
  assign o_Blu_Video = 4'h0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of a default 640x480 instance and a shrunken 20x10 instance
module tb_vga_sync_gen;
  logic clk = 1'b0, rst = 1'b1, rst_s = 1'b1;
  always #5 clk = ~clk;
  logic       hs, vs, act, fs, hs_s, vs_s, act_s, fs_s;
  logic [9:0] col, row, col_s, row_s;
  logic [7:0] fc, fc_s;
  logic [3:0] r, g, b, r_s, g_s, b_s;
  int n_chk = 0, n_fail = 0;
  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  vga_sync_gen dut (
    .i_Clk(clk), .i_Rst(rst), .o_HSync(hs), .o_VSync(vs), .o_Col_Count(col), .o_Row_Count(row),
    .o_Active(act), .o_Frame_Start(fs), .o_Frame_Count(fc), .o_Red_Video(r), .o_Grn_Video(g), .o_Blu_Video(b)
  );
  vga_sync_gen #(
    .c_TOTAL_COLS(20), .c_TOTAL_ROWS(10), .c_ACTIVE_COLS(16), .c_ACTIVE_ROWS(6),
    .c_H_FRONT_PORCH(1), .c_H_SYNC_WIDTH(2), .c_H_BACK_PORCH(1),
    .c_V_FRONT_PORCH(1), .c_V_SYNC_WIDTH(2), .c_V_BACK_PORCH(1)
  ) dut_s (
    .i_Clk(clk), .i_Rst(rst_s), .o_HSync(hs_s), .o_VSync(vs_s), .o_Col_Count(col_s), .o_Row_Count(row_s),
    .o_Active(act_s), .o_Frame_Start(fs_s), .o_Frame_Count(fc_s), .o_Red_Video(r_s), .o_Grn_Video(g_s), .o_Blu_Video(b_s)
  );
  task automatic test_reset();
    rst = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({hs, vs, act, fs} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags: got %b want 1100", {hs, vs, act, fs}); end
    n_chk++; if ({col, row, fc} !== 28'd0) begin n_fail++; $display("FAIL reset_counts: col %0d row %0d fc %0d want 0", col, row, fc); end
    n_chk++; if ({r, g, b} !== 12'h000) begin n_fail++; $display("FAIL reset_colour: got %h want 000", {r, g, b}); end
    n_chk++; if ({hs_s, vs_s, act_s, fs_s, col_s, row_s, fc_s} !== {4'b1100, 28'd0}) begin n_fail++; $display("FAIL reset_small: got %b", {hs_s, vs_s, act_s, fs_s, col_s, row_s, fc_s}); end
  endtask
  task automatic test_release();
    rst = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    n_chk++; if ({col, row} !== 20'd0) begin n_fail++; $display("FAIL release_pos: col %0d row %0d want 0 0", col, row); end
    n_chk++; if ({hs, vs, act, fs} !== 4'b1111) begin n_fail++; $display("FAIL release_flags: got %b want 1111", {hs, vs, act, fs}); end
    n_chk++; if (fc !== 8'd0) begin n_fail++; $display("FAIL release_fc: got %0d want 0", fc); end
    n_chk++; if ({col_s, row_s, act_s, fs_s} !== {20'd0, 2'b11}) begin n_fail++; $display("FAIL release_small: col %0d row %0d act %b fs %b", col_s, row_s, act_s, fs_s); end
  endtask
  task automatic test_line();
    int hs_low = 0, act_hi = 0, first = -1, last = -1, edges = 0, pos_err = 0, act_err = 0;
    logic prev = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (col !== 10'(i) || row !== 10'd0 || vs !== 1'b1) pos_err++;
      if (act !== (i < 640)) act_err++;
      if (!hs) begin hs_low++; if (first < 0) first = i; last = i; end
      if (hs !== prev) edges++;
      prev = hs;
      if (act) act_hi++;
      @(negedge clk);
    end
    n_chk++; if (hs_low != 96) begin n_fail++; $display("FAIL line_hs_width: got %0d want 96", hs_low); end
    n_chk++; if (first != 656 || last != 751) begin n_fail++; $display("FAIL line_hs_span: got %0d..%0d want 656..751", first, last); end
    n_chk++; if (edges != 2) begin n_fail++; $display("FAIL line_hs_edges: got %0d want 2", edges); end
    n_chk++; if (act_hi != 640 || act_err != 0) begin n_fail++; $display("FAIL line_active: got %0d cycles, %0d misplaced, want 640, 0", act_hi, act_err); end
    n_chk++; if (pos_err != 0) begin n_fail++; $display("FAIL line_pos: %0d bad cycles want 0", pos_err); end
    n_chk++; if ({col, row, fs} !== {10'd0, 10'd1, 1'b0}) begin n_fail++; $display("FAIL line_wrap: col %0d row %0d fs %b want 0 1 0", col, row, fs); end
  endtask
  task automatic test_pattern();
    logic found = 1'b0;
    logic [11:0] e85, e600;
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
    e85 = 12'hFF0;
    e600 = 12'h000;
`else
    e85 = 12'h000;
    e600 = 12'h000;
`endif
    for (int i = 0; i < 10000 && !found; i++) begin
      if (row === 10'd10 && col === 10'd85) found = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL pattern_reach: (10,85) not seen within 10000 cycles"); end
    n_chk++; if ({r, g, b} !== e85) begin n_fail++; $display("FAIL pattern_col85: got %h want %h", {r, g, b}, e85); end
    repeat (515) @(negedge clk);
    n_chk++; if ({col, r, g, b} !== {10'd600, e600}) begin n_fail++; $display("FAIL pattern_col600: col %0d rgb %h want 600 %h", col, {r, g, b}, e600); end
    repeat (40) @(negedge clk);
    n_chk++; if ({col, act, r, g, b} !== {10'd640, 1'b0, 12'h000}) begin n_fail++; $display("FAIL pattern_col640: col %0d act %b rgb %h want 640 0 000", col, act, {r, g, b}); end
  endtask
  task automatic test_small_frames();
    int ec = 0, er = 0, ef = 0, last_fs = -1, period_err = 0, n_fs = 0, hs_low = 0, vs_low = 0, prints = 0;
    logic [7:0] fc255 = 8'hxx, fc256 = 8'hxx;
    logic e_act, e_hs, e_vs, e_fs;
    logic [2:0] bar;
    logic [11:0] e_rgb;
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= 256 * 200; i++) begin
      e_act = ec < 16 && er < 6;
      e_hs = !(ec >= 17 && ec <= 18);
      e_vs = !(er >= 7 && er <= 8);
      e_fs = ec == 0 && er == 0;
      bar = bars[ec / 2 % 8];
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
      e_rgb = e_act ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
`else
      e_rgb = 12'h000;
`endif
      n_chk++;
      if ({col_s, row_s, fc_s, hs_s, vs_s, act_s, fs_s, r_s, g_s, b_s} !== {10'(ec), 10'(er), 8'(ef), e_hs, e_vs, e_act, e_fs, e_rgb}) begin
        n_fail++;
        if (prints < 10) $display("FAIL small_cycle %0d: got col %0d row %0d fc %0d hvaf %b%b%b%b rgb %h want col %0d row %0d fc %0d hvaf %b%b%b%b rgb %h",
          i, col_s, row_s, fc_s, hs_s, vs_s, act_s, fs_s, {r_s, g_s, b_s}, ec, er, ef % 256, e_hs, e_vs, e_act, e_fs, e_rgb);
        prints++;
      end
      if (i < 20 && !hs_s) hs_low++;
      if (i < 200 && !vs_s) vs_low++;
      if (fs_s) begin
        if (last_fs >= 0 && i - last_fs != 200) period_err++;
        last_fs = i;
        n_fs++;
      end
      if (i == 255 * 200) fc255 = fc_s;
      if (i == 256 * 200) fc256 = fc_s;
      ec++;
      if (ec == 20) begin
        ec = 0;
        er++;
        if (er == 10) begin er = 0; ef = (ef + 1) % 256; end
      end
      @(negedge clk);
    end
    n_chk++; if (hs_low != 2) begin n_fail++; $display("FAIL small_hs_width: got %0d want 2", hs_low); end
    n_chk++; if (vs_low != 40) begin n_fail++; $display("FAIL small_vs_width: got %0d want 40", vs_low); end
    n_chk++; if (period_err != 0 || n_fs != 257) begin n_fail++; $display("FAIL small_fs_period: %0d bad periods, %0d pulses, want 0, 257", period_err, n_fs); end
    n_chk++; if (fc255 !== 8'd255) begin n_fail++; $display("FAIL small_fc255: got %0d want 255", fc255); end
    n_chk++; if (fc256 !== 8'd0) begin n_fail++; $display("FAIL small_fc_wrap: got %0d want 0", fc256); end
  endtask
  task automatic test_mid_reset();
    logic found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (row_s === 10'd3 && col_s === 10'd17) found = 1'b1;
      else @(negedge clk);
    end
    n_chk++; if (!found || hs_s !== 1'b0) begin n_fail++; $display("FAIL midrst_reach: found %b hs %b want 1 0", found, hs_s); end
    rst_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({hs_s, vs_s, act_s, fs_s, col_s, row_s, fc_s, r_s, g_s, b_s} !== {4'b1100, 40'd0}) begin
        n_fail++;
        $display("FAIL midrst_hold %0d: hvaf %b%b%b%b col %0d row %0d fc %0d want 1100 0 0 0", k, hs_s, vs_s, act_s, fs_s, col_s, row_s, fc_s);
      end
    end
    rst_s = 1'b0;
    @(negedge clk);
    n_chk++; if ({col_s, row_s, hs_s, vs_s, act_s, fs_s, fc_s} !== {20'd0, 4'b1111, 8'd0}) begin n_fail++; $display("FAIL midrst_restart: col %0d row %0d hvaf %b%b%b%b fc %0d", col_s, row_s, hs_s, vs_s, act_s, fs_s, fc_s); end
    @(negedge clk);
    n_chk++; if ({col_s, fs_s, hs_s} !== {10'd1, 1'b0, 1'b1}) begin n_fail++; $display("FAIL midrst_next: col %0d fs %b hs %b want 1 0 1", col_s, fs_s, hs_s); end
  endtask
  initial begin
    test_reset();
    test_release();
    test_line();
    test_pattern();
    test_small_frames();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
